instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch front end: produces the instr_packet stream consumed by the decode stage.
//  Issues in-order word reads to instruction memory and buffers returned words with their PCs.
//  Hands instructions to decode over a valid/ready handshake.
//  Redirects (taken branch/jump) flush the buffer and discard stale in-flight responses.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC of first fetch after reset
//  DEPTH      4              prefetch buffer entries; power of 2, >=2; also max in-flight requests
// PORTS
//  clock           in   1   single clock; all state on rising edge
//  reset           in   1   synchronous, active-high
//  imem_req_valid  out  1   read request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  word-aligned fetch address
//  imem_rsp_valid  in   1   read data valid; in order, no backpressure
//  imem_rsp_data   in   32  instruction word
//  instr_valid     out  1   instr/instr_pc valid to decode
//  instr_ready     in   1   decode consumes this cycle
//  instr           out  32  instruction (instr_packet)
//  instr_pc        out  32  PC of instr
//  redirect        in   1   flush and restart fetch
//  redirect_pc     in   32  new fetch PC; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//  Reset (sampled high at edge): fetch_pc = rsp_pc = RESET_PC; FIFO empty; outstanding = drop_cnt = 0.
//   During/after reset: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013, instr_pc=0.
//   The memory side is reset together with this block; no responses arrive for pre-reset requests.
//  Credits: imem_req_valid = !redirect && (outstanding + fifo_count < DEPTH). The FIFO can never overflow.
//  Request: imem_req_addr = fetch_pc. On valid&&ready: fetch_pc += 4 (mod 2^32), outstanding += 1.
//   Once raised, valid and addr are held stable until accepted, unless redirect withdraws them.
//  Response: each imem_rsp_valid decrements outstanding.
//   drop_cnt>0: word discarded, drop_cnt -= 1.
//   Otherwise: push {imem_rsp_data, rsp_pc} and rsp_pc += 4.
//   Same-cycle request and response: outstanding unchanged.
//  Output: instr_valid = !redirect && fifo_count != 0; instr/instr_pc = FIFO head.
//   When instr_valid=0: instr=32'h0000_0013 (NOP), instr_pc=0.
//   Pop on instr_valid && instr_ready. Push and pop in the same cycle are both honoured.
//  Latency: request accepted in cycle N, response in N+k (k>=1), instr_valid earliest N+k+1.
//   Steady state with k=1, ready=1: one instruction per cycle.
//  Redirect (cycle R):
//   - No request is issued and no pop occurs in R (both valids forced low).
//   - At the end of R: FIFO cleared, fetch_pc = rsp_pc = {redirect_pc[31:2],2'b00}.
//   - drop_cnt = outstanding_after_R; a response arriving in R is itself discarded.
//   - First request for the new PC is possible in R+1.
//  Back-to-back redirects: the last one wins; drop_cnt recomputed each time.
//  Reset has priority over redirect. Counters are sized for 0..DEPTH inclusive.
// TESTING
//  1. Reset, req_ready=1, 1-cycle rsp, instr_ready=1 -> addrs 0,4,8,...; instr_pc 0,4,8 in data order;
//     first instr_valid 2 cycles after first req; then 1/cycle.
//  2. instr_ready=0, DEPTH=4 -> exactly 4 requests then imem_req_valid=0;
//     instr_ready=1 -> drains 0,4,8,C and fetch resumes at 0x10.
//  3. rsp latency 3, redirect_pc=0x100 with 3 in flight -> 3 responses dropped; next instr_pc=0x100;
//     next req addr 0x100 in R+1.
//  4. redirect, imem_rsp_valid and instr_ready high in the same cycle -> no pop, response dropped,
//     FIFO empty in R+1.
//  5. redirect_pc=0xFFFF_FFFE -> req addrs 0xFFFF_FFFC then 0x0000_0000; instr_pc wraps identically.
//  6. reset asserted mid-stream with FIFO non-empty -> next cycle instr_valid=0, instr=0x13;
//     first request after deassert at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited in-order word fetch into a prefetch FIFO,
// valid/ready delivery to decode, and redirect with stale-response dropping.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [31:0]   fetch_pc_q;
  logic [31:0]   rsp_pc_q;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic [31:0] redirect_pc_aligned;
  logic [CW:0] in_use;
  logic        req_fire;
  logic        push;
  logic        pop;

  assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

  // Every request in flight owns a FIFO slot, so the FIFO can never overflow.
  assign in_use         = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid = !reset && !redirect && (in_use < CREDITS);
  assign imem_req_addr  = reset ? RESET_PC : fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push = imem_rsp_valid && !redirect && (drop_cnt_q == '0);

  assign instr_valid = !reset && !redirect && (count_q != '0);
  assign instr       = instr_valid ? data_mem_q[rd_ptr_q] : NOP;
  assign instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign pop         = instr_valid && instr_ready;

  // NOTE: every next-state value gets a default before any branch so no latch can be inferred.
  always_comb begin
    outstanding_d = outstanding_q;
    if (req_fire && !imem_rsp_valid) begin
      outstanding_d = outstanding_q + CNT_ONE;
    end else if (!req_fire && imem_rsp_valid) begin
      outstanding_d = outstanding_q - CNT_ONE;
    end

    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      drop_cnt_d = outstanding_d;
    end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CNT_ONE;
    end

    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      if (redirect) begin
        fetch_pc_q <= redirect_pc_aligned;
        rsp_pc_q   <= redirect_pc_aligned;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
        if (push) begin
          rsp_pc_q <= rsp_pc_q + 32'd4;
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
      end
    end
  end

  // NOTE: the storage array is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      data_mem_q[wr_ptr_q] <= imem_rsp_data;
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: an in-order latency memory plus a tagged-request
// reference model predicting every handshake and delivered instruction.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clock = ~clock;

  instr_fetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  // A request seen by the memory; stale ones belong to a fetch stream abandoned by redirect.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] fifo_m[$];
  logic [31:0] exp_req_pc = RESET_PC;
  int          cyc = 0;
  int          lat = 1;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        s_req_valid;
  logic [31:0] s_addr;
  logic        s_iv;
  logic [31:0] s_instr;
  logic [31:0] s_pc;
  bit          s_rsp;
  bit          prev_hold = 0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A3C_9E71;
  endfunction

  // One clock cycle: drive inputs, sample outputs mid-cycle, compare to the model, advance.
  task automatic step(input bit rr, input bit ir, input bit rd, input logic [31:0] rpc, input bit rst);
    bit exp_rv;
    bit exp_iv;
    reset          = rst;
    imem_req_ready = rr;
    instr_ready    = ir;
    redirect       = rd;
    redirect_pc    = rpc;
    s_rsp          = !rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = s_rsp;
    imem_rsp_data  = s_rsp ? word_of(mem_q[0].addr) : $urandom;
    #1;
    s_req_valid = imem_req_valid;
    s_addr      = imem_req_addr;
    s_iv        = instr_valid;
    s_instr     = instr;
    s_pc        = instr_pc;
    if (rst) begin
      mem_q.delete();
      fifo_m.delete();
      exp_req_pc = RESET_PC;
      prev_hold  = 0;
    end else begin
      exp_rv = !rd && ((mem_q.size() + fifo_m.size()) < DEPTH);
      exp_iv = !rd && (fifo_m.size() != 0);

      n_checks++;
      if (imem_req_valid !== exp_rv) begin
        n_fail++;
        $display("FAIL req_valid cyc=%0d got=%b expected=%b", cyc, imem_req_valid, exp_rv);
      end
      if (exp_rv) begin
        n_checks++;
        if (imem_req_addr !== exp_req_pc) begin
          n_fail++;
          $display("FAIL req_addr cyc=%0d got=%h expected=%h", cyc, imem_req_addr, exp_req_pc);
        end
      end
      if (prev_hold && !rd) begin
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL req_hold cyc=%0d got=%b/%h expected=1/%h", cyc, imem_req_valid, imem_req_addr, prev_addr);
        end
      end

      n_checks++;
      if (instr_valid !== exp_iv) begin
        n_fail++;
        $display("FAIL instr_valid cyc=%0d got=%b expected=%b", cyc, instr_valid, exp_iv);
      end
      if (exp_iv) begin
        n_checks++;
        if (instr !== word_of(fifo_m[0]) || instr_pc !== fifo_m[0]) begin
          n_fail++;
          $display("FAIL instr_head cyc=%0d got=%h@%h expected=%h@%h", cyc, instr, instr_pc,
                   word_of(fifo_m[0]), fifo_m[0]);
        end
      end else begin
        n_checks++;
        if (instr !== NOP || instr_pc !== 32'h0) begin
          n_fail++;
          $display("FAIL instr_idle cyc=%0d got=%h@%h expected=%h@0", cyc, instr, instr_pc, NOP);
        end
      end

      prev_hold = exp_rv && !rr;
      prev_addr = exp_req_pc;
      if (s_rsp) begin
        req_t e;
        e = mem_q.pop_front();
        if (!e.stale && !rd) fifo_m.push_back(e.addr);
      end
      if (exp_iv && ir) void'(fifo_m.pop_front());
      if (exp_rv && rr) begin
        mem_q.push_back('{exp_req_pc, cyc + lat, 1'b0});
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (rd) begin
        fifo_m.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        exp_req_pc = rpc & 32'hFFFF_FFFC;
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    lat = 1;
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got=%b expected=0", s_req_valid); end
    n_checks++;
    if (s_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_req_addr got=%h expected=%h", s_addr, RESET_PC); end
    n_checks++;
    if (s_iv !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got=%b expected=0", s_iv); end
    n_checks++;
    if (s_instr !== NOP || s_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_instr got=%h@%h expected=%h@0", s_instr, s_pc, NOP);
    end
  endtask

  task automatic test_stream();
    int first_req;
    int first_iv;
    int n_iv;
    lat = 1;
    do_reset();
    first_req = -1;
    first_iv  = -1;
    n_iv      = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (s_req_valid && first_req < 0) first_req = i;
      if (s_iv) begin
        if (first_iv < 0) first_iv = i;
        n_iv++;
      end
    end
    n_checks++;
    if (first_req !== 0 || first_iv !== 2) begin
      n_fail++;
      $display("FAIL stream_latency got=req%0d/valid%0d expected=req0/valid2", first_req, first_iv);
    end
    n_checks++;
    if (n_iv !== 18) begin n_fail++; $display("FAIL stream_rate got=%0d expected=18", n_iv); end
  endtask

  task automatic test_backpressure();
    int          n_acc;
    logic [31:0] pcs[$];
    logic [31:0] first_new;
    bit          got;
    lat = 1;
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      if (s_req_valid) n_acc++;
    end
    n_checks++;
    if (n_acc !== DEPTH || s_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_credits got=%0d/%b expected=%0d/0", n_acc, s_req_valid, DEPTH);
    end
    got = 0;
    first_new = '0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (s_iv && pcs.size() < 4) pcs.push_back(s_pc);
      if (s_req_valid && !got) begin
        got = 1;
        first_new = s_addr;
      end
    end
    n_checks++;
    if (pcs.size() !== 4) begin
      n_fail++;
      $display("FAIL bp_drain_count got=%0d expected=4", pcs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (pcs[i] !== 32'(4 * i)) begin
          n_fail++;
          $display("FAIL bp_drain_pc%0d got=%h expected=%h", i, pcs[i], 32'(4 * i));
        end
      end
    end
    n_checks++;
    if (!got || first_new !== 32'h10) begin
      n_fail++;
      $display("FAIL bp_resume got=%b/%h expected=1/00000010", got, first_new);
    end
  endtask

  task automatic test_redirect_inflight();
    int          n_acc;
    logic [31:0] first_pc;
    bit          got;
    lat = 3;
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (s_req_valid) n_acc++;
    end
    n_checks++;
    if (n_acc !== 3) begin n_fail++; $display("FAIL rd_inflight got=%0d expected=3", n_acc); end
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    n_checks++;
    if (s_req_valid !== 1'b0 || s_iv !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_cycle_valids got=%b/%b expected=0/0", s_req_valid, s_iv);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL rd_next_req got=%b/%h expected=1/00000100", s_req_valid, s_addr);
    end
    got = 0;
    first_pc = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (s_iv) begin
        got = 1;
        first_pc = s_pc;
      end
    end
    n_checks++;
    if (!got || first_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL rd_first_pc got=%b/%h expected=1/00000100", got, first_pc);
    end
  endtask

  task automatic test_redirect_collision();
    logic [31:0] first_pc;
    bit          got;
    lat = 1;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (s_iv !== 1'b1) begin n_fail++; $display("FAIL col_prefill got=%b expected=1", s_iv); end
    step(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
    n_checks++;
    if (s_iv !== 1'b0 || s_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL col_r_valids got=%b/%b expected=0/0", s_iv, s_req_valid);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (s_iv !== 1'b0) begin n_fail++; $display("FAIL col_r1_empty got=%b expected=0", s_iv); end
    got = 0;
    first_pc = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (s_iv) begin
        got = 1;
        first_pc = s_pc;
      end
    end
    n_checks++;
    if (!got || first_pc !== 32'h40) begin
      n_fail++;
      $display("FAIL col_first_pc got=%b/%h expected=1/00000040", got, first_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    lat = 1;
    do_reset();
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (s_req_valid && addrs.size() < 2) addrs.push_back(s_addr);
      if (s_iv && pcs.size() < 2) pcs.push_back(s_pc);
    end
    n_checks++;
    if (addrs.size() !== 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_req_addrs got=%0d entries %h,%h expected=2 entries fffffffc,00000000",
               addrs.size(), addrs[0], addrs[1]);
    end
    n_checks++;
    if (pcs.size() !== 2 || pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_instr_pcs got=%0d entries %h,%h expected=2 entries fffffffc,00000000",
               pcs.size(), pcs[0], pcs[1]);
    end
  endtask

  task automatic test_reset_midstream();
    lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (s_iv !== 1'b1) begin n_fail++; $display("FAIL mid_prefill got=%b expected=1", s_iv); end
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (s_iv !== 1'b0 || s_instr !== NOP || s_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_out got=%b %h@%h expected=0 %h@0", s_iv, s_instr, s_pc, NOP);
    end
    n_checks++;
    if (s_req_valid !== 1'b1 || s_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL mid_reset_req got=%b/%h expected=1/%h", s_req_valid, s_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    bit          rr;
    bit          ir;
    bit          rd;
    bit          rst;
    logic [31:0] rpc;
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      lat = $urandom_range(1, 4);
      for (int i = 0; i < 500; i++) begin
        rr  = ($urandom_range(0, 3) != 0);
        ir  = ($urandom_range(0, 2) != 0);
        rd  = ($urandom_range(0, 24) == 0);
        rst = ($urandom_range(0, 399) == 0);
        rpc = $urandom;
        step(rr, ir, rd, rpc, rst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collision();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
